// File: rtl/soc_pkg.sv
// Shared SOC word-bus types plus the timer scheduler's register map and config types.
package soc_pkg;

   localparam int unsigned SOC_DATAW    = 32;
   localparam int unsigned SOC_ADDRW    = 32;
   localparam int unsigned PERIOD_PS    = 18_518;
   localparam int unsigned NUM_1US_CLKS = 53;
   localparam int unsigned TMR_MAX_CH   = 4;

   typedef logic [SOC_ADDRW-1:0]   soc_addr_t;
   typedef logic [SOC_DATAW/8-1:0] soc_we_t;
   typedef logic [SOC_DATAW-1:0]   soc_data_t;
   typedef logic [5:0]             cnt_1us_t;

   typedef enum logic [3:0] {
      TMR_CTRL   = 4'd0,
      TMR_USEC   = 4'd1,
      TMR_STATUS = 4'd2,
      TMR_LOAD0  = 4'd4,
      TMR_CFG0   = 4'd5,
      TMR_LOAD1  = 4'd6,
      TMR_CFG1   = 4'd7,
      TMR_LOAD2  = 4'd8,
      TMR_CFG2   = 4'd9,
      TMR_LOAD3  = 4'd10,
      TMR_CFG3   = 4'd11
   } tmr_reg_t;

   typedef struct packed {
      logic ie;
      logic periodic;
      logic en;
   } tmr_cfg_t;

   function automatic soc_data_t be_merge(soc_data_t old, soc_data_t wdat, soc_we_t we);
      soc_data_t m;
      m = '0;
      for (int unsigned b = 0; b < SOC_DATAW/8; b++) m[8*b +: 8] = {8{we[b]}};
      return (old & ~m) | (wdat & m);
   endfunction

   // Word index of a channel's LOAD register; its CFG register follows at +1.
   function automatic logic [3:0] tmr_load_idx(int unsigned ch);
      return 4'(4 + 2*ch);
   endfunction

endpackage

// File: rtl/soc_timer_sched_if.sv
// Request/response word bus between the CPU side and the timer scheduler.
interface soc_timer_sched_if;
   import soc_pkg::*;

   logic      vld;
   soc_addr_t addr;
   soc_we_t   we;
   soc_data_t wdat;
   logic      rdy;
   soc_data_t rdat;

   modport master (output vld, addr, we, wdat, input rdy, rdat);
   modport slave  (input vld, addr, we, wdat, output rdy, rdat);

endinterface

// File: rtl/soc_timebase.sv
// 1 us prescaler: emits a one-clock strobe every NUM_1US_CLKS+1 clocks while enabled.
module soc_timebase
   import soc_pkg::*;
(
   input  logic clk,
   input  logic arst,
   input  logic en,
   output logic tick
);

   cnt_1us_t cnt_q;

   assign tick = en && (cnt_q == cnt_1us_t'(NUM_1US_CLKS));

   always_ff @(posedge clk or posedge arst) begin
      if (arst)              cnt_q <= '0;
      else if (!en || tick)  cnt_q <= '0;
      else                   cnt_q <= cnt_q + cnt_1us_t'(1);
   end

endmodule

// File: rtl/soc_timer_sched.sv
// Timer scheduler: shared 1 us timebase, free-running USEC counter and NUM_CH down-counting channels.
module soc_timer_sched
   import soc_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              arst,
   soc_timer_sched_if.slave  bus,
   output logic              tick_1us,
   output logic              irq
);

   localparam int unsigned NCH = (NUM_CH < TMR_MAX_CH) ? NUM_CH : TMR_MAX_CH;

   logic            req, wr, wr_b0;
   logic [3:0]      idx;
   logic            glb_en_q;
   soc_data_t       usec_q;
   logic [NCH-1:0]  status_q, fire, ie_v, w1c;
   logic            rdy_q;
   soc_data_t       rdat_q, rd_val;
   logic [CNT_W-1:0] load_v [NCH];
   tmr_cfg_t        cfg_v [NCH];
   logic            unused_addr;

   assign req   = bus.vld & ~bus.rdy;
   assign wr    = req & (|bus.we);
   assign wr_b0 = wr & bus.we[0];
   assign idx   = bus.addr[5:2];
   assign unused_addr = ^{bus.addr[SOC_ADDRW-1:6], bus.addr[1:0]};

   assign bus.rdy  = rdy_q;
   assign bus.rdat = rdat_q;

   soc_timebase u_timebase (
      .clk  (clk),
      .arst (arst),
      .en   (glb_en_q),
      .tick (tick_1us)
   );

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [CNT_W-1:0] load_q, count_q;
      tmr_cfg_t         cfg_q;
      logic             load_wr, cfg_wr;

      assign load_wr = wr && (idx == tmr_load_idx(i));
      assign cfg_wr  = wr_b0 && (idx == tmr_load_idx(i) + 4'd1);
      // A CFG write in the tick cycle takes priority, so that tick neither fires nor counts.
      assign fire[i] = tick_1us && cfg_q.en && (count_q == '0) && !cfg_wr;

      always_ff @(posedge clk or posedge arst) begin
         if (arst) begin
            load_q  <= '0;
            count_q <= '0;
            cfg_q   <= '0;
         end else begin
            if (load_wr) load_q <= CNT_W'(be_merge(SOC_DATAW'(load_q), bus.wdat, bus.we));
            if (cfg_wr) begin
               cfg_q <= tmr_cfg_t'(bus.wdat[2:0]);
               if (bus.wdat[0]) count_q <= load_q;
            end else if (tick_1us && cfg_q.en) begin
               if (count_q == '0) begin
                  if (cfg_q.periodic) count_q <= load_q;
                  else                cfg_q.en <= 1'b0;
               end else begin
                  count_q <= count_q - CNT_W'(1);
               end
            end
         end
      end

      assign load_v[i] = load_q;
      assign cfg_v[i]  = cfg_q;
      assign ie_v[i]   = cfg_q.ie;
   end

   assign w1c = (wr_b0 && (idx == TMR_STATUS)) ? bus.wdat[NCH-1:0] : '0;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         glb_en_q <= 1'b0;
         usec_q   <= '0;
         status_q <= '0;
         irq      <= 1'b0;
      end else begin
         if (wr_b0 && (idx == TMR_CTRL)) glb_en_q <= bus.wdat[0];
         if (wr && (idx == TMR_USEC))    usec_q   <= be_merge(usec_q, bus.wdat, bus.we);
         else if (tick_1us)              usec_q   <= usec_q + SOC_DATAW'(1);
         status_q <= (status_q & ~w1c) | fire;
         irq      <= |(status_q & ie_v);
      end
   end

   always_comb begin
      rd_val = '0;
      case (idx)
         TMR_CTRL:   rd_val = SOC_DATAW'(glb_en_q);
         TMR_USEC:   rd_val = usec_q;
         TMR_STATUS: rd_val = SOC_DATAW'(status_q);
         default: begin
            for (int unsigned c = 0; c < NCH; c++) begin
               if (idx == tmr_load_idx(c))        rd_val = SOC_DATAW'(load_v[c]);
               if (idx == tmr_load_idx(c) + 4'd1) rd_val = SOC_DATAW'(cfg_v[c]);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         rdy_q  <= 1'b0;
         rdat_q <= '0;
      end else begin
         rdy_q  <= req;
         rdat_q <= (req && !wr) ? rd_val : '0;
      end
   end

endmodule

// File: tb/tb_soc_timer_sched.sv
// Scoreboarded bench for soc_timer_sched against a tick-level behavioural model of the timer.
module tb_soc_timer_sched;
   import soc_pkg::*;

   typedef struct {
      bit          is_rd;
      logic [31:0] data;
   } sb_t;

   logic clk  = 1'b0;
   logic arst = 1'b1;
   logic tick, irq;
   int   checks = 0;
   int   errors = 0;

   soc_timer_sched_if bus_if ();

   soc_timer_sched #(.NUM_CH(4), .CNT_W(32)) dut (
      .clk      (clk),
      .arst     (arst),
      .bus      (bus_if),
      .tick_1us (tick),
      .irq      (irq)
   );

   always #(PERIOD_PS/2) clk = ~clk;

   // Reference model state, advanced once per clock edge.
   bit          m_en, m_irq, m_rdy;
   int          m_pre;
   logic [31:0] m_usec;
   logic [31:0] m_load [4];
   logic [31:0] m_cnt  [4];
   bit          m_cen [4];
   bit          m_per [4];
   bit          m_ie  [4];
   logic [3:0]  m_stat;
   sb_t         exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(int w);
      int c;
      if (w == 0) return {31'b0, m_en};
      if (w == 1) return m_usec;
      if (w == 2) return {28'b0, m_stat};
      if (w >= 4 && w <= 11) begin
         c = (w - 4) / 2;
         if (w % 2 == 0) return m_load[c];
         return {29'b0, m_ie[c], m_per[c], m_cen[c]};
      end
      return 32'h0;
   endfunction

   task automatic model_reset();
      m_en = 0; m_irq = 0; m_rdy = 0; m_pre = 0; m_usec = 0; m_stat = 0;
      for (int c = 0; c < 4; c++) begin
         m_load[c] = 0; m_cnt[c] = 0; m_cen[c] = 0; m_per[c] = 0; m_ie[c] = 0;
      end
      exp_q.delete();
   endtask

   task automatic model_step();
      bit          req, tk, new_irq, cfgw;
      int          w, c;
      logic [31:0] mask, d;
      logic [3:0]  we, fires, w1c, iev;
      sb_t         e;
      req  = bus_if.vld && !m_rdy;
      we   = bus_if.we;
      d    = bus_if.wdat;
      w    = int'(bus_if.addr[5:2]);
      tk   = m_en && (m_pre == 53);
      mask = 0;
      for (int b = 0; b < 4; b++) if (we[b]) mask[8*b +: 8] = 8'hFF;
      if (req) begin
         e.is_rd = (we == 4'h0);
         e.data  = model_read(w);
         exp_q.push_back(e);
      end
      iev = 0;
      for (int k = 0; k < 4; k++) iev[k] = m_ie[k];
      new_irq = |(m_stat & iev);
      fires = 0;
      w1c   = 0;
      for (int k = 0; k < 4; k++) begin
         cfgw = req && we[0] && (w == 5 + 2*k);
         if (tk && m_cen[k] && !cfgw) begin
            if (m_cnt[k] == 0) begin
               fires[k] = 1'b1;
               if (m_per[k]) m_cnt[k] = m_load[k];
               else          m_cen[k] = 0;
            end else begin
               m_cnt[k] = m_cnt[k] - 32'd1;
            end
         end
      end
      if (tk) m_usec = m_usec + 32'd1;
      m_pre = !m_en ? 0 : ((m_pre == 53) ? 0 : m_pre + 1);
      if (req && we != 4'h0) begin
         if (w == 0) begin
            if (we[0]) m_en = d[0];
         end else if (w == 1) begin
            m_usec = (m_usec & ~mask) | (d & mask);
         end else if (w == 2) begin
            if (we[0]) w1c = d[3:0];
         end else if (w >= 4 && w <= 11) begin
            c = (w - 4) / 2;
            if (w % 2 == 0) m_load[c] = (m_load[c] & ~mask) | (d & mask);
            else if (we[0]) begin
               m_cen[c] = d[0]; m_per[c] = d[1]; m_ie[c] = d[2];
               if (d[0]) m_cnt[c] = m_load[c];
            end
         end
      end
      m_stat = (m_stat & ~w1c) | fires;
      m_irq  = new_irq;
      m_rdy  = req;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge arst);
         if (arst) model_reset();
         else      model_step();
      end
   end

   // Monitor: per-cycle output checks and scoreboard pops on each completion.
   initial begin
      sb_t e;
      forever begin
         @(negedge clk);
         chk("tick_1us", 32'(tick), 32'(m_en && (m_pre == 53)));
         chk("irq", 32'(irq), 32'(m_irq));
         chk("bus_rdy", 32'(bus_if.rdy), 32'(m_rdy));
         if (arst) chk("rdat_in_reset", bus_if.rdat, 32'h0);
         if (bus_if.rdy === 1'b1) begin
            if (exp_q.size() == 0) chk("rdy_unexpected", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               if (e.is_rd) chk("rdat", bus_if.rdat, e.data);
            end
         end
      end
   end

   initial begin
      repeat (200000) @(posedge clk);
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic bus_xfer(input logic [3:0] w, input logic [3:0] we, input logic [31:0] d);
      int n, expn;
      expn = m_rdy ? 2 : 1;
      n = 0;
      bus_if.vld  = 1'b1;
      bus_if.addr = {26'b0, w, 2'b00};
      bus_if.we   = we;
      bus_if.wdat = d;
      do begin
         @(negedge clk);
         n++;
      end while (bus_if.rdy !== 1'b1 && n < 4);
      chk("bus_latency", 32'(n), 32'(expn));
      bus_if.vld = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_pre53();
      int n;
      n = 0;
      idle(1);
      while (m_pre != 53 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("tick_alignment_wait", 32'(m_pre), 32'd53);
   endtask

   initial begin
      int          n;
      int unsigned w;
      logic [3:0]  we;
      logic [31:0] d;
      bus_if.vld = 0; bus_if.addr = 0; bus_if.we = 0; bus_if.wdat = 0;
      idle(3);
      arst = 1'b0;
      idle(1);

      for (int unsigned i = 0; i < 16; i++) bus_xfer(4'(i), 4'h0, 32'h0);
      idle(200);

      // Timebase period
      bus_xfer(4'd0, 4'h1, 32'h1);
      n = 0;
      while (tick !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      n = 0;
      do begin @(negedge clk); n++; end while (tick !== 1'b1 && n < 200);
      chk("tick_period", 32'(n), 32'd54);
      idle(540);
      bus_xfer(4'd1, 4'h0, 32'h0);

      // ch0 one-shot with interrupt
      bus_xfer(4'd4, 4'hF, 32'd3);
      bus_xfer(4'd5, 4'h1, 32'h5);
      idle(54*5 + 10);
      chk("irq_oneshot", 32'(irq), 32'd1);
      bus_xfer(4'd5, 4'h0, 32'h0);
      bus_xfer(4'd2, 4'h0, 32'h0);
      bus_xfer(4'd2, 4'h1, 32'h1);
      idle(3);
      chk("irq_after_w1c", 32'(irq), 32'd0);
      bus_xfer(4'd2, 4'h0, 32'h0);

      // ch1 fires every tick; W1C collides with a tick
      bus_xfer(4'd6, 4'hF, 32'd0);
      bus_xfer(4'd7, 4'h1, 32'h7);
      idle(60);
      wait_pre53();
      bus_xfer(4'd2, 4'h1, 32'h2);
      bus_xfer(4'd2, 4'h0, 32'h0);
      bus_xfer(4'd7, 4'h1, 32'h0);
      bus_xfer(4'd2, 4'h1, 32'hF);

      // USEC wrap and partial LOAD write
      bus_xfer(4'd1, 4'hF, 32'hFFFF_FFFF);
      idle(60);
      bus_xfer(4'd1, 4'h0, 32'h0);
      bus_xfer(4'd8, 4'hF, 32'h1234_5678);
      bus_xfer(4'd8, 4'b0010, 32'h0000_AB00);
      bus_xfer(4'd8, 4'h0, 32'h0);

      // Randomised traffic
      for (int i = 0; i < 300; i++) begin
         w  = $urandom_range(0, 15);
         we = ($urandom_range(0, 1) == 1) ? 4'h0 :
              (($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'hF);
         d  = $urandom;
         if (w >= 4 && w % 2 == 0) d = $urandom_range(0, 6);
         if (w == 0) d = ($urandom_range(0, 9) == 0) ? 32'h0 : 32'h1;
         if (w == 1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - $urandom_range(0, 3);
         bus_xfer(4'(w), we, d);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 80));
         if ($urandom_range(0, 15) == 0) idle(54 * $urandom_range(1, 8));
      end
      for (int unsigned i = 0; i < 16; i++) bus_xfer(4'(i), 4'h0, 32'h0);

      // Reset in the middle of a read
      bus_if.vld = 1'b1; bus_if.addr = 32'h4; bus_if.we = 4'h0;
      #(PERIOD_PS/4) arst = 1'b1;
      idle(3);
      bus_if.vld = 1'b0;
      arst = 1'b0;
      idle(1);
      bus_xfer(4'd1, 4'h0, 32'h0);
      bus_xfer(4'd2, 4'h0, 32'h0);
      idle(4);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/soc_timer_sched.md
# soc_timer_sched

Shared timer scheduler for the SOC: it owns the 1 µs timebase prescaler and time-multiplexes the resulting tick across `NUM_CH` down-counting timer channels, all configured over the SOC word bus. It sits on the peripheral bus next to the CPU. It provides a free-running microsecond counter, per-channel one-shot/periodic expiry flags, and a single level interrupt to the CPU.

## Interface
- `NUM_CH`, default 4: number of timer channels; legal range 1..4 (register map is fixed to 4 slots).
- `CNT_W`, default 32: width of channel LOAD/count registers; must be ≤ `SOC_DATAW`.
- `clk`  in  1: SOC clock, 54 MHz (`PERIOD_PS` = 18_518).
- `arst`  in  1: reset; asynchronous and active-high.
- `bus_vld`  in  1: request valid.
- `bus_addr`  in  `soc_addr_t`: word address; only bits [5:2] are decoded.
- `bus_we`  in  `soc_we_t`: per-byte write enables; all-zero means read.
- `bus_wdat`  in  `soc_data_t`: write data.
- `bus_rdy`  out  1: one-cycle completion pulse.
- `bus_rdat`  out  `soc_data_t`: read data, valid only while `bus_rdy`=1.
- `tick_1us`  out  1: one-clk pulse every 1 µs while enabled.
- `irq`  out  1: level interrupt, OR over channels of (status & ie).

## Operation
Register map (byte offsets):
- 0x00 CTRL: bit0 `glb_en`.
- 0x04 USEC: free-running 32-bit µs counter. Read/write.
- 0x08 STATUS: bits[NUM_CH-1:0] expiry flags. Write-1-to-clear.
- 0x10+8·ch LOAD.
- 0x14+8·ch CFG: bit0 `en`, bit1 `periodic`, bit2 `ie`.
- Unmapped or absent-channel offsets read 0 and ignore writes.

Byte-enable rules:
- LOAD and USEC honour all byte enables.
- CTRL, CFG and STATUS use byte0 only.

Prescaler:
- Width `cnt_1us_t`; counts 0..`NUM_1US_CLKS` (=53).
- `tick_1us`=1 in the cycle the count equals `NUM_1US_CLKS`; the count wraps to 0 in that same cycle.
- `glb_en`=0: prescaler held at 0, no ticks are generated, USEC and all channels frozen.

Counters on each tick:
- USEC increments and wraps 0xFFFF_FFFF→0.

Per-channel behaviour on each tick, when `en`=1:
- If `count`==0: set STATUS[ch].
  - `periodic`=1: reload `count`=LOAD.
  - `periodic`=0: clear `en`.
- Otherwise: `count` decrements.
- Resulting period is LOAD+1 µs. With LOAD=0 and `periodic`=1, the channel fires on every tick.

Channel arming:
- A CFG write with `en`=1 loads `count`=LOAD.
- A CFG write with `en`=0 stops the channel; `count` is held.

Simultaneous events:
- CFG write and tick on the same channel in the same cycle: the write wins, the count is loaded, and that tick is ignored for the channel.
- STATUS W1C and a hardware set on the same bit in the same cycle: the set wins.
- USEC write and tick in the same cycle: the write wins.

## Timing
Bus handshake:
- A request is sampled in any cycle with `bus_vld`=1 and `bus_rdy`=0.
- `bus_rdy` pulses exactly 1 cycle later, so latency is 1 cycle.
- Requester holds addr/we/wdat stable until `bus_rdy`, then deasserts `bus_vld` or presents the next request.
- Back-to-back throughput: 1 request per 2 cycles.

Write and read timing:
- Write effects are visible in registers in the `bus_rdy` cycle.
- Read data is registered from the sample cycle.

Output timing:
- STATUS sets in the cycle after the qualifying tick.
- `irq` is registered, so it rises 1 cycle after STATUS.

Reset values (`arst`=1):
- All registers 0, prescaler 0, `count` 0.
- `bus_rdy`=0, `bus_rdat`=0, `tick_1us`=0, `irq`=0.
- Reset mid-transaction drops the transaction; no `bus_rdy` is issued.

## Structure
Add to `soc_pkg`:
- `tmr_reg_t`: enum of word offsets.
- `tmr_cfg_t`: packed struct {ie, periodic, en}.
- `TMR_MAX_CH` = 4.

Sub-modules:
- `soc_timebase`: holds the prescaler and `tick_1us`; reused by any block needing a µs strobe.
- Channel logic stays as a generate loop inside `soc_timer_sched`.

## Test plan
- Reset, then read every register → all read 0; `irq`=0; no `tick_1us` for 200 clk.
- Write CTRL=1 → `tick_1us` period is exactly 54 clk; USEC reads 10 after 540 clk ±1 tick.
- ch0 LOAD=3, CFG=0b101 (one-shot, ie) → STATUS[0] sets 4 µs after arming, `irq`=1, CFG.en reads 0; W1C STATUS=1 → `irq`=0.
- ch1 LOAD=0, CFG=0b111 → STATUS[1] is set on every tick; W1C in the same cycle as a tick leaves the bit set.
- USEC written 0xFFFF_FFFF → reads 0 after the next tick. Partial write `bus_we`=0b0010, data 0x0000_AB00 to LOAD2 → only byte1 changes.
- Assert `arst` mid-read with `bus_vld`=1 → no `bus_rdy`; all outputs 0; a fresh read after release completes in 1 cycle.
